moving_rank_filter: RTL and testbench
=====================================

Name: moving_rank_filter

Overview:
Parametrised successor to the fixed 5-tap, 16-bit moving median. It keeps a sliding window of the last DEPTH accepted samples and sorts each window snapshot through a fully pipelined odd-even transposition network. It outputs the element at a runtime-selectable rank: min, median, max or any order statistic. It sits in the same instrument signal path as the median filter, between ADC-rate sample sources and downstream averaging or DAC logic, and adds a valid strobe so sparse or decimated streams are handled.

Parameters:
- WIDTH, 16: sample width in bits; samples are two's-complement signed.
- DEPTH, 5: window length; odd, legal range 3..15; elaboration error otherwise.
- RW, $clog2(DEPTH): width of the Rank port. Derived; not to be overridden.

Ports:
- Clk, input, 1: clock; all logic is on its rising edge.
- Reset, input, 1: synchronous, active-high reset.
- InValid, input, 1: Input is accepted in any cycle where this is high.
- Input, input, WIDTH: signed sample.
- Rank, input, RW: order statistic to output; 0 = min, (DEPTH-1)/2 = median, DEPTH-1 = max.
- OutValid, output, 1: one-cycle pulse marking a new Output.
- Output, output, WIDTH: signed selected element; holds its value between pulses.
- Primed, output, 1: high once DEPTH samples have been accepted since reset.

Behaviour:
- Reset: window, all sort stages, valid tags, Output, OutValid, Primed and the sample counter are cleared to 0 on the next edge. Reset mid-stream discards all in-flight tokens; no OutValid may follow from pre-reset samples.
- Window: when InValid=1, the window shifts and Input enters slot 0; slot DEPTH-1 is dropped. When InValid=0 the window holds.
- Snapshot (stage 0): registers the window together with a valid tag and Rank. The tag equals InValid delayed by one cycle. Rank is captured here and travels with the snapshot, so a Rank change affects only snapshots taken afterwards.
- Sort stages 1..DEPTH:
  - Odd-numbered stages compare-exchange pairs (0,1), (2,3), ...
  - Even-numbered stages compare-exchange pairs (1,2), (3,4), ...
  - The unpaired element passes through.
  - Each compare is signed; the smaller value goes to the lower index. Ties do not swap.
  - After DEPTH stages the vector is fully ascending.
- Output stage: when the last stage's tag is 1, Output is loaded with sorted[min(Rank, DEPTH-1)] and OutValid=1. Otherwise Output holds and OutValid=0.
- Latency: InValid high in cycle c gives OutValid high in cycle c+DEPTH+3, which is 8 for DEPTH=5 and matches the legacy block.
- Throughput: one result per accepted sample. There is no backpressure and no stall. Back-to-back InValid yields back-to-back OutValid.
- Counter: saturates at DEPTH. Primed goes high in the cycle after the DEPTH-th accepted sample and stays high until Reset.
- Warm-up: with the optional feature off, missing window slots read as 0, as in the legacy block.
- Out-of-range Rank (values DEPTH..2^RW-1) clamps to DEPTH-1.
- Widths: no arithmetic is performed, only comparisons. The full range -2^(WIDTH-1)..2^(WIDTH-1)-1 must sort correctly.

Optional Feature:
- Macro: MOVING_RANK_WARMUP_EN.
- Defined: a token's valid tag is forced to 0 if Primed was 0 when the snapshot was taken. No OutValid occurs until the window contains DEPTH real samples, and zero-fill never reaches Output.
- Undefined: every accepted sample produces an OutValid, with zero-filled slots during warm-up.

Decomposition:
- Package moving_rank_pkg holds the sample typedef (signed logic [WIDTH-1:0]), the DEPTH legality check function and the rank-clamp function.
- Sub-module cmp_swap: a combinational signed compare-exchange of two elements, instantiated per pair per stage. The parent owns all registers.

Test Plan:
- Reset, then Input 10, -3, 7, 7, 0 on consecutive cycles with Rank=2 -> the fifth OutValid arrives 8 cycles after the last input with Output=7. Repeat with Rank=0 -> -3; Rank=4 -> 10.
- Window {-32768, 32767, -1, 0, 1}, Rank=2 -> Output=0; Rank=4 -> 32767 (signed extremes).
- Same samples as the first case with InValid gapped 1-of-3 -> identical Output sequence; OutValid count equals accepted samples; Output holds between pulses.
- Feature off: single sample 100 after reset, Rank=4 -> Output=100; Rank=2 -> 0. Feature on: no OutValid for the first 4 samples; Primed rises after sample 5.
- Stream at full rate, assert Reset for 1 cycle mid-stream -> OutValid=0 and Output=0 after the edge; the first new OutValid appears exactly 8 cycles after the first post-reset InValid.
- Rank=6 (RW=3, DEPTH=5) -> behaves as Rank=4 (max); change Rank mid-stream -> it takes effect exactly on the token snapshotted after the change.

Source files
------------

// File: rtl/moving_rank_filter_pkg.sv
// ---------------------------------------------------------------------------
// moving_rank_pkg
//   Shared types and helpers for the moving rank filter.
//   - sample_t        : the 16-bit signed sample used on the instrument path.
//                       The filter itself uses a local type of its own WIDTH.
//   - depth_is_legal  : elaboration-time check of the window length.
//   - clamp_rank      : maps an out-of-range rank onto the maximum.
// ---------------------------------------------------------------------------
package moving_rank_pkg;

  localparam int SAMPLE_WIDTH = 16;
  localparam int DEPTH_MIN    = 3;
  localparam int DEPTH_MAX    = 15;

  typedef logic signed [SAMPLE_WIDTH-1:0] sample_t;

  // The odd window length makes the median a single element.
  function automatic bit depth_is_legal(input int depth);
    return (depth >= DEPTH_MIN) && (depth <= DEPTH_MAX) && ((depth % 2) == 1);
  endfunction

  // Ranks from depth up to the top of the port range select the maximum.
  function automatic int clamp_rank(input int rank, input int depth);
    return (rank >= depth) ? (depth - 1) : rank;
  endfunction

endpackage

// File: rtl/moving_rank_filter_cmp_swap.sv
// ---------------------------------------------------------------------------
// cmp_swap
//   Combinational signed compare-exchange used by every sorting lane.
//   Ports:
//     a, b   : input pair (a sits at the lower index)
//     lo, hi : smaller value, larger value
//   Equal values keep their order, so ties never swap.
// ---------------------------------------------------------------------------
module cmp_swap
  import moving_rank_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [WIDTH-1:0] lo,
  output logic signed [WIDTH-1:0] hi
);

  logic swap;

  // Both operands are declared signed, so this is a two's-complement compare.
  assign swap = (b < a);
  assign lo   = swap ? b : a;
  assign hi   = swap ? a : b;

endmodule

// File: rtl/moving_rank_filter.sv
// ---------------------------------------------------------------------------
// moving_rank_filter
//   Sliding window of the last DEPTH accepted samples, sorted every cycle by
//   a fully pipelined odd-even transposition network, with the element at a
//   runtime-selected rank (0 = min, (DEPTH-1)/2 = median, DEPTH-1 = max)
//   presented on Output.
//
//   Ports:
//     Clk      : clock, rising edge
//     Reset    : synchronous, active-high
//     InValid  : Input is accepted in this cycle
//     Input    : signed sample
//     Rank     : order statistic; values >= DEPTH select the maximum
//     OutValid : one-cycle pulse for a new Output
//     Output   : selected element, held between pulses
//     Primed   : DEPTH samples have been accepted since reset
//
//   Pipeline: window -> snapshot (stage 0) -> sort stages 1..DEPTH -> output.
//   InValid in cycle c gives OutValid in cycle c+DEPTH+3.
//
//   Build option MOVING_RANK_WARMUP_EN: when defined, snapshots taken before
//   Primed carry a cleared valid tag, so zero-filled warm-up windows never
//   reach Output. When undefined, every accepted sample produces a result and
//   missing window slots read as 0.
// ---------------------------------------------------------------------------
module moving_rank_filter
  import moving_rank_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 5,
  localparam int RW    = $clog2(DEPTH)
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    InValid,
  input  logic signed [WIDTH-1:0] Input,
  input  logic        [RW-1:0]    Rank,
  output logic                    OutValid,
  output logic signed [WIDTH-1:0] Output,
  output logic                    Primed
);

  if (!depth_is_legal(DEPTH)) begin : g_bad_depth
    $error("moving_rank_filter: DEPTH=%0d must be odd and within 3..15", DEPTH);
  end

  localparam int             CW         = $clog2(DEPTH + 1);
  localparam logic [CW-1:0]  COUNT_FULL = CW'(DEPTH);

  typedef logic signed [WIDTH-1:0] elem_t;

  elem_t           window   [DEPTH];
  logic            valid_d1;
  logic [CW-1:0]   count;
  logic            primed;
  logic            snap_tag;

  // stg_*[0] is the snapshot; stg_*[k] is the output of sort stage k.
  elem_t           stg_data  [DEPTH+1][DEPTH];
  logic [DEPTH:0]  stg_valid;
  logic [RW-1:0]   stg_rank  [DEPTH+1];

  // net[k-1] is the combinational result of sort stage k.
  elem_t           net       [DEPTH][DEPTH];

  logic [RW-1:0]   sel;

  assign primed = (count == COUNT_FULL);
  assign Primed = primed;

`ifdef MOVING_RANK_WARMUP_EN
  assign snap_tag = valid_d1 & primed;
`else
  assign snap_tag = valid_d1;
`endif

  // Odd stages pair (0,1),(2,3)...; even stages pair (1,2),(3,4)...
  // DEPTH alternating stages fully sort DEPTH elements.
  for (genvar k = 1; k <= DEPTH; k++) begin : g_stage
    localparam int FIRST = (k % 2 == 1) ? 0 : 1;
    for (genvar i = 0; i < DEPTH; i++) begin : g_lane
      localparam bit IS_LOWER = (i >= FIRST) && (((i - FIRST) % 2) == 0) &&
                                (i + 1 < DEPTH);
      localparam bit IS_UPPER = (i - 1 >= FIRST) && (((i - 1 - FIRST) % 2) == 0);
      if (IS_LOWER) begin : g_pair
        cmp_swap #(.WIDTH(WIDTH)) u_cmp (
          .a  (stg_data[k-1][i]),
          .b  (stg_data[k-1][i+1]),
          .lo (net[k-1][i]),
          .hi (net[k-1][i+1])
        );
      end else if (!IS_UPPER) begin : g_pass
        assign net[k-1][i] = stg_data[k-1][i];
      end
    end
  end

  assign sel = RW'(clamp_rank(int'(stg_rank[DEPTH]), DEPTH));

  // NOTE: every register here uses <= so all stages sample the values from
  // before the edge; a blocking assignment would let a token skip stages.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      // NOTE: the window and sort stages are real state, not scratch memory:
      // zero-fill during warm-up and dropping in-flight tokens both rely on
      // clearing them here.
      for (int i = 0; i < DEPTH; i++) window[i] <= '0;
      for (int k = 0; k <= DEPTH; k++) begin
        for (int i = 0; i < DEPTH; i++) stg_data[k][i] <= '0;
        stg_rank[k] <= '0;
      end
      stg_valid <= '0;
      valid_d1  <= 1'b0;
      count     <= '0;
      OutValid  <= 1'b0;
      Output    <= '0;
    end else begin
      valid_d1 <= InValid;
      if (InValid) begin
        window[0] <= Input;
        for (int i = 1; i < DEPTH; i++) window[i] <= window[i-1];
        if (count != COUNT_FULL) count <= count + CW'(1);
      end

      // Rank is captured with the snapshot so it follows that token only.
      stg_data[0]  <= window;
      stg_valid[0] <= snap_tag;
      stg_rank[0]  <= Rank;

      for (int k = 1; k <= DEPTH; k++) begin
        stg_data[k]  <= net[k-1];
        stg_valid[k] <= stg_valid[k-1];
        stg_rank[k]  <= stg_rank[k-1];
      end

      OutValid <= stg_valid[DEPTH];
      if (stg_valid[DEPTH]) Output <= stg_data[DEPTH][sel];
    end
  end

endmodule

// File: tb/tb_moving_rank_filter.sv
// ---------------------------------------------------------------------------
// tb_moving_rank_filter
//   Directed bench for moving_rank_filter at WIDTH=16, DEPTH=5.
//   Inputs change on the falling edge; outputs are observed on the falling
//   edge. A cycle index (cyc) advances on every rising edge, so a sample
//   driven while cyc == X produces its pulse at the falling edge where
//   cyc == X+8.
//   Build option MOVING_RANK_WARMUP_EN changes which pulses are expected.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_moving_rank_filter;
  import moving_rank_pkg::*;

  localparam int WIDTH = 16;
  localparam int DEPTH = 5;
  localparam int RW    = 3;
  localparam int LAT   = DEPTH + 3;
`ifdef MOVING_RANK_WARMUP_EN
  localparam int SKIP  = DEPTH - 1;   // warm-up pulses are suppressed
`else
  localparam int SKIP  = 0;
`endif

  logic          Clk = 1'b0;
  logic          Reset;
  logic          InValid;
  sample_t       Input;
  logic [RW-1:0] Rank;
  logic          OutValid;
  sample_t       Output;
  logic          Primed;

  moving_rank_filter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .InValid  (InValid),
    .Input    (Input),
    .Rank     (Rank),
    .OutValid (OutValid),
    .Output   (Output),
    .Primed   (Primed)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  sample_t out_q[$];
  int      out_cyc_q[$];
  int      hold_q[$];
  int      drive_q[$];
  sample_t prev_out = '0;

  always @(negedge Clk) begin
    if (OutValid) begin
      out_q.push_back(Output);
      out_cyc_q.push_back(cyc);
    end else if (Output !== prev_out) begin
      hold_q.push_back(cyc);
    end
    prev_out <= Output;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input int v, input int r);
    @(negedge Clk);
    InValid = 1'b1;
    Input   = sample_t'(v);
    Rank    = RW'(r);
    drive_q.push_back(cyc);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge Clk);
      InValid = 1'b0;
      Input   = '0;
    end
  endtask

  task automatic apply_reset;
    @(negedge Clk);
    Reset   = 1'b1;
    InValid = 1'b0;
    @(negedge Clk);
    Reset   = 1'b0;
    idle(1);
  endtask

  task automatic clear_monitor;
    out_q.delete();
    out_cyc_q.delete();
    hold_q.delete();
    drive_q.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    Reset   = 1'b1;
    InValid = 1'b1;
    Input   = 16'sd1234;
    Rank    = '0;
    repeat (3) @(negedge Clk);
    n_checks++;
    if (OutValid !== 1'b0) begin
      n_errors++; $display("FAIL reset_outvalid: got %b expected 0", OutValid);
    end
    n_checks++;
    if (Output !== '0) begin
      n_errors++; $display("FAIL reset_output: got %0d expected 0", Output);
    end
    n_checks++;
    if (Primed !== 1'b0) begin
      n_errors++; $display("FAIL reset_primed: got %b expected 0", Primed);
    end
    Reset   = 1'b0;
    InValid = 1'b0;
    idle(2);
  endtask

  task automatic test_order_stats;
    int smp[5]        = '{10, -3, 7, 7, 0};
    int ranks[3]      = '{2, 0, 4};
    int exp_tab[3][5] = '{'{0, 0, 0, 7, 7}, '{0, -3, -3, -3, -3}, '{10, 10, 10, 10, 10}};
    for (int r = 0; r < 3; r++) begin
      apply_reset();
      clear_monitor();
      for (int i = 0; i < 5; i++) send(smp[i], ranks[r]);
      idle(LAT + 4);
      n_checks++;
      if (out_q.size() != 5 - SKIP) begin
        n_errors++;
        $display("FAIL order_r%0d_count: got %0d expected %0d", ranks[r], out_q.size(), 5 - SKIP);
      end
      for (int i = SKIP; i < 5; i++) begin
        sample_t got;
        got = (i - SKIP < out_q.size()) ? out_q[i - SKIP] : 'x;
        n_checks++;
        if (got !== sample_t'(exp_tab[r][i])) begin
          n_errors++;
          $display("FAIL order_r%0d_s%0d: got %0d expected %0d", ranks[r], i, got, exp_tab[r][i]);
        end
      end
      n_checks++;
      if (out_cyc_q.size() == 0 || out_cyc_q[out_cyc_q.size()-1] - drive_q[4] != LAT) begin
        n_errors++;
        $display("FAIL order_r%0d_latency: got %0d expected %0d", ranks[r],
                 (out_cyc_q.size() == 0) ? -1 : out_cyc_q[out_cyc_q.size()-1] - drive_q[4], LAT);
      end
    end
  endtask

  task automatic test_extremes;
    int smp[5]   = '{-32768, 32767, -1, 0, 1};
    int ranks[3] = '{2, 4, 0};
    int expv[3]  = '{0, 32767, -32768};
    for (int r = 0; r < 3; r++) begin
      apply_reset();
      clear_monitor();
      for (int i = 0; i < 5; i++) send(smp[i], ranks[r]);
      idle(LAT + 4);
      n_checks++;
      if (out_q.size() != 5 - SKIP || out_q[out_q.size()-1] !== sample_t'(expv[r])) begin
        n_errors++;
        $display("FAIL extreme_r%0d: got %0d (count %0d) expected %0d (count %0d)", ranks[r],
                 (out_q.size() == 0) ? 0 : out_q[out_q.size()-1], out_q.size(), expv[r], 5 - SKIP);
      end
    end
  endtask

  task automatic test_gapped;
    int smp[5]  = '{10, -3, 7, 7, 0};
    int expv[5] = '{0, 0, 0, 7, 7};
    apply_reset();
    clear_monitor();
    for (int i = 0; i < 5; i++) begin
      send(smp[i], 2);
      idle(2);
    end
    idle(LAT + 4);
    n_checks++;
    if (out_q.size() != 5 - SKIP) begin
      n_errors++; $display("FAIL gapped_count: got %0d expected %0d", out_q.size(), 5 - SKIP);
    end
    for (int i = SKIP; i < 5; i++) begin
      sample_t got;
      got = (i - SKIP < out_q.size()) ? out_q[i - SKIP] : 'x;
      n_checks++;
      if (got !== sample_t'(expv[i])) begin
        n_errors++; $display("FAIL gapped_s%0d: got %0d expected %0d", i, got, expv[i]);
      end
    end
    n_checks++;
    if (hold_q.size() != 0) begin
      n_errors++; $display("FAIL gapped_hold: got %0d changes without OutValid expected 0", hold_q.size());
    end
  endtask

  task automatic test_warmup;
`ifdef MOVING_RANK_WARMUP_EN
    int smp[5] = '{10, -3, 7, 7, 0};
    apply_reset();
    clear_monitor();
    for (int i = 0; i < 4; i++) send(smp[i], 2);
    idle(LAT + 4);
    n_checks++;
    if (out_q.size() != 0) begin
      n_errors++; $display("FAIL warmup_on_silent: got %0d pulses expected 0", out_q.size());
    end
    n_checks++;
    if (Primed !== 1'b0) begin
      n_errors++; $display("FAIL warmup_on_primed4: got %b expected 0", Primed);
    end
    send(smp[4], 2);
    idle(1);
    n_checks++;
    if (Primed !== 1'b1) begin
      n_errors++; $display("FAIL warmup_on_primed5: got %b expected 1", Primed);
    end
    idle(LAT + 4);
    n_checks++;
    if (out_q.size() != 1 || out_q[0] !== 16'sd7) begin
      n_errors++;
      $display("FAIL warmup_on_first: got %0d (count %0d) expected 7 (count 1)",
               (out_q.size() == 0) ? 0 : out_q[0], out_q.size());
    end
`else
    int ranks[2] = '{4, 2};
    int expv[2]  = '{100, 0};
    for (int r = 0; r < 2; r++) begin
      apply_reset();
      clear_monitor();
      send(100, ranks[r]);
      idle(LAT + 4);
      n_checks++;
      if (out_q.size() != 1 || out_q[0] !== sample_t'(expv[r])) begin
        n_errors++;
        $display("FAIL warmup_off_r%0d: got %0d (count %0d) expected %0d (count 1)", ranks[r],
                 (out_q.size() == 0) ? 0 : out_q[0], out_q.size(), expv[r]);
      end
    end
`endif
  endtask

  task automatic test_primed;
    apply_reset();
    for (int i = 0; i < 4; i++) send(i + 1, 2);
    idle(1);
    n_checks++;
    if (Primed !== 1'b0) begin
      n_errors++; $display("FAIL primed_after4: got %b expected 0", Primed);
    end
    send(5, 2);
    idle(1);
    n_checks++;
    if (Primed !== 1'b1) begin
      n_errors++; $display("FAIL primed_after5: got %b expected 1", Primed);
    end
    for (int i = 0; i < 4; i++) send(i, 2);
    idle(2);
    n_checks++;
    if (Primed !== 1'b1) begin
      n_errors++; $display("FAIL primed_stays: got %b expected 1", Primed);
    end
  endtask

  task automatic test_reset_midstream;
    apply_reset();
    clear_monitor();
    for (int i = 1; i <= 10; i++) send(100 + i, 4);
    n_checks++;
    if (out_q.size() == 0) begin
      n_errors++; $display("FAIL midreset_prefill: got 0 pulses expected at least 1");
    end
    @(negedge Clk);
    Reset   = 1'b1;
    InValid = 1'b0;
    @(negedge Clk);
    Reset   = 1'b0;
    n_checks++;
    if (OutValid !== 1'b0 || Output !== '0) begin
      n_errors++;
      $display("FAIL midreset_clear: got OutValid=%b Output=%0d expected 0/0", OutValid, Output);
    end
    n_checks++;
    if (Primed !== 1'b0) begin
      n_errors++; $display("FAIL midreset_primed: got %b expected 0", Primed);
    end
    clear_monitor();
    idle(2);
    for (int i = 0; i < 5; i++) send(50 + i, 4);
    idle(LAT + 4);
    n_checks++;
    if (out_q.size() != 5 - SKIP) begin
      n_errors++; $display("FAIL midreset_count: got %0d expected %0d", out_q.size(), 5 - SKIP);
    end
    n_checks++;
    if (out_cyc_q.size() == 0 || out_cyc_q[0] - drive_q[SKIP] != LAT) begin
      n_errors++;
      $display("FAIL midreset_latency: got %0d expected %0d",
               (out_cyc_q.size() == 0) ? -1 : out_cyc_q[0] - drive_q[SKIP], LAT);
    end
    for (int i = SKIP; i < 5; i++) begin
      sample_t got;
      got = (i - SKIP < out_q.size()) ? out_q[i - SKIP] : 'x;
      n_checks++;
      if (got !== sample_t'(50 + i)) begin
        n_errors++; $display("FAIL midreset_s%0d: got %0d expected %0d", i, got, 50 + i);
      end
    end
  endtask

  task automatic test_rank_clamp_and_change;
    int smp[8]  = '{10, -3, 7, 7, 0, 5, -8, 2};
    // Rank switches 0 -> 4 while sample 7 is driven; the snapshot taken on
    // that edge belongs to sample 6.
    int rnk[8]  = '{0, 0, 0, 0, 0, 0, 4, 4};
    int expv[8] = '{0, -3, -3, -3, -3, 7, 7, 7};
    apply_reset();
    clear_monitor();
    for (int i = 0; i < 5; i++) send(smp[i], 6);
    idle(LAT + 4);
    n_checks++;
    if (out_q.size() != 5 - SKIP || out_q[out_q.size()-1] !== 16'sd10) begin
      n_errors++;
      $display("FAIL rank6_clamp: got %0d (count %0d) expected 10 (count %0d)",
               (out_q.size() == 0) ? 0 : out_q[out_q.size()-1], out_q.size(), 5 - SKIP);
    end
    for (int i = SKIP; i < 5; i++) begin
      n_checks++;
      if (i - SKIP >= out_q.size() || out_q[i - SKIP] !== 16'sd10) begin
        n_errors++;
        $display("FAIL rank6_s%0d: got %0d expected 10", i,
                 (i - SKIP < out_q.size()) ? out_q[i - SKIP] : 0);
      end
    end

    apply_reset();
    clear_monitor();
    for (int i = 0; i < 8; i++) send(smp[i], rnk[i]);
    idle(LAT + 4);
    n_checks++;
    if (out_q.size() != 8 - SKIP) begin
      n_errors++; $display("FAIL rankchg_count: got %0d expected %0d", out_q.size(), 8 - SKIP);
    end
    for (int i = SKIP; i < 8; i++) begin
      sample_t got;
      got = (i - SKIP < out_q.size()) ? out_q[i - SKIP] : 'x;
      n_checks++;
      if (got !== sample_t'(expv[i])) begin
        n_errors++; $display("FAIL rankchg_s%0d: got %0d expected %0d", i, got, expv[i]);
      end
    end
  endtask

  initial begin
    Reset   = 1'b1;
    InValid = 1'b0;
    Input   = '0;
    Rank    = '0;
    test_reset();
    test_order_stats();
    test_extremes();
    test_gapped();
    test_warmup();
    test_primed();
    test_reset_midstream();
    test_rank_clamp_and_change();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
